// File: rtl/spi_pkg.sv
// Shared types for the N-bit SPI master.
//   spi_state_t : frame sequencer states
//   spi_cfg_t   : per-frame mode flags captured when a frame is accepted
//   sclk_level  : SCLK level that belongs to a given sequencer state
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPHA_DLY = 2'd1,
    P0       = 2'd2,
    P1       = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
    logic ss_hold;
  } spi_cfg_t;

  // SCLK leaves its idle level in P1 for cpha=0 and in P0 for cpha=1.
  function automatic logic sclk_level(input spi_state_t st, input logic cpol, input logic cpha);
    return cpol ^ (((st == P1) & ~cpha) | ((st == P0) & cpha));
  endfunction

endpackage

// File: rtl/spi_halfper_cnt.sv
// SCLK half-period counter.
//   clr_i         : force count to zero (held while the sequencer is idle)
//   en_i          : count one clk cycle
//   dvsr_i        : terminal count (half-period = dvsr_i+1 cycles)
//   expire_o      : current cycle is the last one of the half-period
//   expire_next_o : the following cycle will be the last one of a half-period
module spi_halfper_cnt #(
  parameter int DVSR_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DVSR_W-1:0] dvsr_i,
  output logic              expire_o,
  output logic              expire_next_o
);

  logic [DVSR_W-1:0] cnt_q;
  logic [DVSR_W-1:0] cnt_d;

  // Count up to dvsr_i then restart at zero, so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == dvsr_i) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DVSR_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o      = (cnt_q == dvsr_i);
  assign expire_next_o = (cnt_d == dvsr_i);

endmodule

// File: rtl/spi_master_nbit.sv
// Parametrised SPI master: DATA_W-bit frames, CPOL/CPHA modes, MSB/LSB-first,
// NUM_SS active-low slave selects with optional hold across frames.
//   clk_i/reset_n_i       : clock, synchronous active-low reset
//   din_i/dout_o          : word to send / last complete received word
//   dvsr_i                : SCLK half-period = dvsr_i+1 clk cycles
//   start_i/ready_o       : frame request (taken only when ready_o=1)
//   cpol_i/cpha_i         : SPI mode; lsb_first_i selects shift direction
//   ss_sel_i/ss_hold_i    : slave to address / keep it selected after the frame
//   spi_done_tick_o       : one-cycle pulse in the last cycle of a frame
//   sclk_o/mosi_o/miso_i/ss_n_o : SPI pins
module spi_master_nbit
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 1,
  parameter int DVSR_W = 16,
  localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  input  logic [DVSR_W-1:0] dvsr_i,
  input  logic              start_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic [SS_W-1:0]   ss_sel_i,
  input  logic              ss_hold_i,
  output logic              ready_o,
  output logic              spi_done_tick_o,
  output logic              sclk_o,
  input  logic              miso_i,
  output logic              mosi_o,
  output logic [NUM_SS-1:0] ss_n_o
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  spi_state_t        state_q, state_d;
  spi_cfg_t          cfg_q, cfg_d;
  logic [DVSR_W-1:0] dvsr_q;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, rx_q, dout_q;
  logic [NUM_SS-1:0] ss_n_q, ss_mask;
  logic              sclk_q, sclk_d, tick_q, tick_d;
  logic              accept, expire, expire_next;

  assign accept  = (state_q == IDLE) && start_i;
  // With a single select line the address is meaningless.
  assign ss_mask = (NUM_SS == 1) ? NUM_SS'(1) : (NUM_SS'(1) << ss_sel_i);

  spi_halfper_cnt #(.DVSR_W(DVSR_W)) u_halfper_cnt (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .clr_i         (state_q == IDLE),
    .en_i          (state_q != IDLE),
    .dvsr_i        (dvsr_q),
    .expire_o      (expire),
    .expire_next_o (expire_next)
  );

  // Next state, bit index, active config and registered-output lookahead.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    cfg_d   = cfg_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = cpha_i ? CPHA_DLY : P0;
          bit_d   = '0;
          cfg_d   = '{cpol: cpol_i, cpha: cpha_i, lsb_first: lsb_first_i, ss_hold: ss_hold_i};
        end else begin
          state_d = IDLE;
        end
      end
      CPHA_DLY: begin
        if (expire) state_d = P0;
        else        state_d = CPHA_DLY;
      end
      P0: begin
        if (expire) state_d = P1;
        else        state_d = P0;
      end
      P1: begin
        if (expire && (bit_q == LAST_BIT)) begin
          state_d = IDLE;
        end else if (expire) begin
          state_d = P0;
          bit_d   = bit_q + BIT_W'(1);
        end else begin
          state_d = P1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The done pulse is registered one cycle early so it lands on the final P1 cycle.
    tick_d = (state_d == P1) && (bit_d == LAST_BIT) && expire_next;
    // Idle SCLK follows the live cpol; inside a frame only the latched mode counts.
    sclk_d = (state_d == IDLE) ? cpol_i : sclk_level(state_d, cfg_d.cpol, cfg_d.cpha);
  end

  // Sequencer, shift registers, slave selects and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      dvsr_q  <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      ss_n_q  <= '1;
      sclk_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      tick_q  <= tick_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            dvsr_q <= dvsr_i;
            tx_q   <= din_i;
            // Retarget immediately; a previously held line is released on the same edge.
            ss_n_q <= ~ss_mask;
          end
        end
        P0: begin
          if (expire) begin
            rx_q <= cfg_q.lsb_first ? {miso_i, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso_i};
          end
        end
        P1: begin
          if (expire && (bit_q == LAST_BIT)) begin
            dout_q <= rx_q;
            if (!cfg_q.ss_hold) ss_n_q <= '1;
          end else if (expire) begin
            tx_q <= cfg_q.lsb_first ? (tx_q >> 1) : (tx_q << 1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o         = (state_q == IDLE);
  assign spi_done_tick_o = tick_q;
  assign sclk_o          = sclk_q;
  assign mosi_o          = cfg_q.lsb_first ? tx_q[0] : tx_q[DATA_W-1];
  assign ss_n_o          = ss_n_q;
  assign dout_o          = dout_q;

endmodule

// File: tb/tb_spi_master_nbit.sv
// Bench for spi_master_nbit: an 8-bit / 4-select instance (with a behavioural
// SPI slave) and a 16-bit / 1-select loopback instance.
module tb_spi_master_nbit;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // 8-bit instance
  logic [7:0]  a_din, a_dout;
  logic [15:0] a_dvsr;
  logic        a_start, a_cpol, a_cpha, a_lsb, a_hold;
  logic [1:0]  a_sel;
  logic        a_ready, a_tick, a_sclk, a_miso, a_mosi;
  logic [3:0]  a_ss_n;

  spi_master_nbit #(.DATA_W(8), .NUM_SS(4), .DVSR_W(16)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .din_i(a_din), .dout_o(a_dout), .dvsr_i(a_dvsr),
    .start_i(a_start), .cpol_i(a_cpol), .cpha_i(a_cpha), .lsb_first_i(a_lsb),
    .ss_sel_i(a_sel), .ss_hold_i(a_hold), .ready_o(a_ready), .spi_done_tick_o(a_tick),
    .sclk_o(a_sclk), .miso_i(a_miso), .mosi_o(a_mosi), .ss_n_o(a_ss_n)
  );

  // 16-bit instance, miso looped back from mosi
  logic [15:0] b_din, b_dout, b_dvsr;
  logic        b_start, b_cpol, b_cpha, b_lsb, b_hold, b_sel;
  logic        b_ready, b_tick, b_sclk, b_mosi;
  logic [0:0]  b_ss_n;

  spi_master_nbit #(.DATA_W(16), .NUM_SS(1), .DVSR_W(16)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .din_i(b_din), .dout_o(b_dout), .dvsr_i(b_dvsr),
    .start_i(b_start), .cpol_i(b_cpol), .cpha_i(b_cpha), .lsb_first_i(b_lsb),
    .ss_sel_i(b_sel), .ss_hold_i(b_hold), .ready_o(b_ready), .spi_done_tick_o(b_tick),
    .sclk_o(b_sclk), .miso_i(b_mosi), .mosi_o(b_mosi), .ss_n_o(b_ss_n)
  );

  // Behavioural SPI slave for the 8-bit instance: on every sampling edge of
  // SCLK it records mosi and moves on to its next outgoing bit.
  logic       slave_rst, slave_en, m_cpol, m_cpha, m_lsb;
  logic [7:0] slave_word, mosi_seen;
  int         slave_idx;

  always @(a_sclk or posedge slave_rst) begin
    if (slave_rst) begin
      slave_idx <= 0;
    end else if (a_sclk == (m_cpol ^ ~m_cpha)) begin
      if (slave_idx < 8) mosi_seen[slave_idx] <= a_mosi;
      slave_idx <= slave_idx + 1;
    end
  end

  always_comb begin
    a_miso = a_mosi;
    if (slave_en) begin
      if (slave_idx < 8) a_miso = m_lsb ? slave_word[slave_idx] : slave_word[7 - slave_idx];
      else               a_miso = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame length in clk cycles from the accepting edge to the done pulse.
  function automatic int exp_latency(input int w, input int d, input logic cpha);
    return 2 * w * (d + 1) + (cpha ? (d + 1) : 0);
  endfunction

  // Bit k of the result is the k-th bit put on the wire.
  function automatic logic [7:0] wire_order(input logic [7:0] w, input logic lsb);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = lsb ? w[k] : w[7 - k];
    return r;
  endfunction

  task automatic frame8(input logic [7:0] din, input logic [15:0] dvsr, input logic cpol,
                        input logic cpha, input logic lsb, input logic [1:0] sel,
                        input logic hold, input logic sen, input logic [7:0] sword,
                        input int glitch_at, input string tag);
    int         n;
    int         bad;
    logic [3:0] exp_ss;
    logic [7:0] exp_dout;
    exp_ss   = ~(4'b0001 << sel);
    exp_dout = sen ? sword : din;
    @(negedge clk);
    a_din = din; a_dvsr = dvsr; a_cpol = cpol; a_cpha = cpha; a_lsb = lsb;
    a_sel = sel; a_hold = hold; a_start = 1'b1;
    slave_en = sen; slave_word = sword; m_cpol = cpol; m_cpha = cpha; m_lsb = lsb;
    slave_rst = 1'b1;
    @(negedge clk);
    a_start = 1'b0; slave_rst = 1'b0;
    n = 1; bad = 0;
    while (a_tick !== 1'b1 && n < 4000) begin
      if (a_ss_n !== exp_ss || a_ready !== 1'b0) bad++;
      if (n == glitch_at) begin
        a_start = 1'b1; a_din = ~din; a_cpol = ~cpol; a_cpha = ~cpha; a_lsb = ~lsb;
      end else begin
        a_start = 1'b0; a_din = din; a_cpol = cpol; a_cpha = cpha; a_lsb = lsb;
      end
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_latency(8, int'(dvsr), cpha)));
    check({tag, " ss_n/ready in frame"}, 32'(bad), 32'd0);
    check({tag, " ss_n at done"}, 32'(a_ss_n), 32'(exp_ss));
    check({tag, " sample edges"}, 32'(slave_idx), 32'd8);
    check({tag, " mosi sequence"}, 32'(mosi_seen), 32'(wire_order(din, lsb)));
    @(negedge clk);
    check({tag, " tick width"}, 32'(a_tick), 32'd0);
    check({tag, " ready after"}, 32'(a_ready), 32'd1);
    check({tag, " dout"}, 32'(a_dout), 32'(exp_dout));
    check({tag, " ss_n after"}, 32'(a_ss_n), hold ? 32'(exp_ss) : 32'hF);
    check({tag, " sclk idle"}, 32'(a_sclk), 32'(cpol));
  endtask

  task automatic frame16(input logic [15:0] din, input logic [15:0] dvsr, input logic cpha,
                         input logic lsb, input string tag);
    int n;
    @(negedge clk);
    b_din = din; b_dvsr = dvsr; b_cpha = cpha; b_lsb = lsb; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    n = 1;
    while (b_tick !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_latency(16, int'(dvsr), cpha)));
    check({tag, " ss_n at done"}, 32'(b_ss_n), 32'd0);
    @(negedge clk);
    check({tag, " ready after"}, 32'(b_ready), 32'd1);
    check({tag, " dout"}, 32'(b_dout), 32'(din));
    check({tag, " ss_n after"}, 32'(b_ss_n), 32'd1);
  endtask

  initial begin
    int n;
    int ticks;
    rst_n = 1'b0;
    a_din = 8'h00; a_dvsr = 16'd0; a_start = 1'b0; a_cpol = 1'b0; a_cpha = 1'b0;
    a_lsb = 1'b0; a_sel = 2'd0; a_hold = 1'b0;
    b_din = 16'h0000; b_dvsr = 16'd0; b_start = 1'b0; b_cpol = 1'b0; b_cpha = 1'b0;
    b_lsb = 1'b0; b_sel = 1'b0; b_hold = 1'b0;
    slave_rst = 1'b1; slave_en = 1'b0; slave_word = 8'h00;
    m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of both instances
    check("reset ready", 32'({a_ready, b_ready}), 32'h3);
    check("reset dout", 32'({a_dout, b_dout}), 32'h0);
    check("reset ss_n", 32'({a_ss_n, b_ss_n}), 32'h1F);
    check("reset sclk/mosi/tick", 32'({a_sclk, a_mosi, a_tick, b_sclk, b_mosi, b_tick}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0 loopback, dvsr=1
    frame8(8'hA5, 16'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, -1, "t1");
    // Mode 3, dvsr=0, slave returns C3
    frame8(8'h3C, 16'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'hC3, -1, "t2");
    // LSB-first single set bit
    frame8(8'h01, 16'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, -1, "t3");
    // Held select across two frames to slave 2
    frame8(8'h11, 16'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 8'h00, -1, "t4a");
    frame8(8'h22, 16'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 8'h00, -1, "t4b");
    // start and live mode changes mid-frame are ignored
    frame8(8'h5A, 16'd1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'h00, 5, "t5");

    // Reset at cycle 10 of a frame
    @(negedge clk);
    a_din = 8'hFF; a_dvsr = 16'd1; a_cpol = 1'b0; a_cpha = 1'b0; a_lsb = 1'b0;
    a_sel = 2'd3; a_hold = 1'b1; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid ready low", 32'(a_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid-reset ready", 32'(a_ready), 32'd1);
    check("mid-reset ss_n", 32'(a_ss_n), 32'hF);
    check("mid-reset sclk/mosi/tick", 32'({a_sclk, a_mosi, a_tick}), 32'd0);
    check("mid-reset dout", 32'(a_dout), 32'h0);
    ticks = 0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (a_tick === 1'b1) ticks++;
    end
    check("mid-reset no tick", 32'(ticks), 32'd0);

    // 16-bit loopback, dvsr=2
    frame16(16'hBEEF, 16'd2, 1'b0, 1'b0, "t6");

    // Randomised frames against the reference model
    for (int i = 0; i < 12; i++) begin
      frame8(8'($urandom), 16'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
             -1, $sformatf("r8_%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      frame16(16'($urandom), 16'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
              $sformatf("r16_%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
